// File: rtl/button_bounce_gen_pkg.sv
// ---------------------------------------------------------------------------
// button_gen_pkg
//   Shared types and constants for the bouncy push-button stimulus source and
//   for other test-pattern blocks built around the same 16-bit LFSR.
//
//   state_t            : sequencer states of button_bounce_gen
//   LFSR_TAPS          : Galois feedback mask (x^16 + x^14 + x^13 + x^11 + 1)
//   LFSR_SEED_DEFAULT  : default nonzero LFSR reset value
//   SEG_CNT_W          : width of the glitch/gap segment counter
//   lfsr_step()        : one right-shift Galois step
// ---------------------------------------------------------------------------
package button_gen_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GAP    = 2'd1,
    GLITCH = 2'd2,
    SETTLE = 2'd3
  } state_t;

  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

  // Wide enough for MIN_CYC plus a 16-bit random offset.
  localparam int SEG_CNT_W = 17;

  // Right-shift Galois step. Zero maps to zero and every other state maps to
  // a nonzero state, so a nonzero seed keeps the register out of zero forever.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

endpackage

// File: rtl/button_bounce_gen_lfsr16.sv
// ---------------------------------------------------------------------------
// lfsr16
//   Free-running 16-bit Galois LFSR (taps 16'hB400). Advances on every clock
//   after reset; there is no enable. SEED must be nonzero.
//
//   clk    : system clock
//   rst_n  : asynchronous active-low reset, loads SEED
//   q      : current LFSR state
// ---------------------------------------------------------------------------
module lfsr16
  import button_gen_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] q
);

  // NOTE: clocked state is always written with non-blocking assignments so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= SEED;
    end else begin
      q <= lfsr_step(q);
    end
  end

endmodule

// File: rtl/button_bounce_gen.sv
// ---------------------------------------------------------------------------
// button_bounce_gen
//   Synthesizable emulation of a mechanical push-button. On a start request
//   the output line moves to the requested level, then bounces back to the old
//   level BOUNCES times. Every gap (line at target) and every glitch (line at
//   old level) lasts MIN_CYC + lfsr[WIDTH_BITS-1:0] cycles. After the last gap
//   the line is held at target for HOLD_COUNTS cycles and done pulses.
//   A request whose level already matches the line skips straight to the hold.
//
//   Parameter limits: MIN_CYC >= 1, WIDTH_BITS <= 16, HOLD_COUNTS >= 1,
//   LFSR_SEED nonzero.
//
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   start  : one-cycle request, ignored while busy
//   level  : requested target level, sampled with start
//   button : emulated bouncy button line (registered)
//   busy   : high while a sequence is in progress
//   done   : one-cycle pulse when the line has been stable for HOLD_COUNTS
// ---------------------------------------------------------------------------
module button_bounce_gen
  import button_gen_pkg::*;
#(
  parameter int          BOUNCES     = 4,
  parameter int          MIN_CYC     = 16,
  parameter int          WIDTH_BITS  = 10,
  parameter int          HOLD_COUNTS = 5000,
  parameter logic        IDLE_LEVEL  = 1'b0,
  parameter logic [15:0] LFSR_SEED   = LFSR_SEED_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic level,
  output logic button,
  output logic busy,
  output logic done
);

  localparam int GLITCH_W = (BOUNCES > 0) ? $clog2(BOUNCES + 1) : 1;
  localparam int HOLD_W   = $clog2(HOLD_COUNTS + 1);

  localparam logic [15:0]          LEN_MASK    = 16'((32'd1 << WIDTH_BITS) - 32'd1);
  localparam logic [SEG_CNT_W-1:0] MIN_LOAD    = SEG_CNT_W'(MIN_CYC - 1);
  localparam logic [HOLD_W-1:0]    HOLD_LOAD   = HOLD_W'(HOLD_COUNTS - 1);
  localparam logic [GLITCH_W-1:0]  GLITCH_INIT = GLITCH_W'(BOUNCES);

  state_t               state;
  logic                 tgt;
  logic [15:0]          lfsr_q;
  logic [SEG_CNT_W-1:0] seg_cnt;
  logic [SEG_CNT_W-1:0] seg_load;
  logic [HOLD_W-1:0]    hold_cnt;
  logic [GLITCH_W-1:0]  glitches_left;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr_q)
  );

  // Counters count down to zero, so a segment of L cycles loads L-1.
  assign seg_load = MIN_LOAD + {1'b0, lfsr_q & LEN_MASK};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      button        <= IDLE_LEVEL;
      busy          <= 1'b0;
      done          <= 1'b0;
      tgt           <= IDLE_LEVEL;
      seg_cnt       <= '0;
      hold_cnt      <= '0;
      glitches_left <= '0;
    end else begin
      done <= 1'b0;

      unique case (state)
        IDLE: begin
          if (start) begin
            tgt  <= level;
            busy <= 1'b1;
            if (level != button) begin
              button        <= level;
              glitches_left <= GLITCH_INIT;
              seg_cnt       <= seg_load;
              state         <= GAP;
            end else begin
              hold_cnt <= HOLD_LOAD;
              state    <= SETTLE;
            end
          end
        end

        GAP: begin
          if (seg_cnt == '0) begin
            if (glitches_left != '0) begin
              button  <= ~tgt;
              seg_cnt <= seg_load;
              state   <= GLITCH;
            end else begin
              hold_cnt <= HOLD_LOAD;
              state    <= SETTLE;
            end
          end else begin
            seg_cnt <= seg_cnt - 1'b1;
          end
        end

        GLITCH: begin
          if (seg_cnt == '0) begin
            button        <= tgt;
            glitches_left <= glitches_left - 1'b1;
            seg_cnt       <= seg_load;
            state         <= GAP;
          end else begin
            seg_cnt <= seg_cnt - 1'b1;
          end
        end

        SETTLE: begin
          // busy drops in the same cycle done rises; the FSM is already IDLE
          // then, so a start presented alongside done is accepted.
          if (hold_cnt == '0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_bounce_gen.sv
// ---------------------------------------------------------------------------
// tb_button_bounce_gen
//   Three generator instances share clk/rst_n:
//     [0] BOUNCES=3, MIN_CYC=4,  WIDTH_BITS=3,  HOLD_COUNTS=20
//     [1] BOUNCES=0, MIN_CYC=4,  WIDTH_BITS=3,  HOLD_COUNTS=20
//     [2] BOUNCES=4, MIN_CYC=16, WIDTH_BITS=10, HOLD_COUNTS=5000, feeding a
//         debounce model with DELAY_COUNTS=2500
//   Expected segment lengths come from an independent LFSR model and are
//   queued when a request is driven, then popped as button edges appear.
// ---------------------------------------------------------------------------
module tb_button_bounce_gen;

  localparam int MIN_A    = 4;
  localparam int WB_A     = 3;
  localparam int HOLD_A   = 20;
  localparam int MIN_C    = 16;
  localparam int WB_C     = 10;
  localparam int HOLD_C   = 5000;
  localparam int DELAY    = 2500;
  localparam int LAT_MAX  = 2500 + 1039 + 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] start_v = '0;
  logic [2:0] level_v = '0;
  logic [2:0] btn_v;
  logic [2:0] busy_v;
  logic [2:0] done_v;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [15:0] lfsr_m;

  logic db;
  int   db_cnt;
  logic db_prev = 1'b0;
  int   db_rises = 0;
  int   db_falls = 0;
  int   db_cyc = 0;

  always #5 clk = ~clk;

  button_bounce_gen #(
    .BOUNCES(3), .MIN_CYC(MIN_A), .WIDTH_BITS(WB_A), .HOLD_COUNTS(HOLD_A),
    .IDLE_LEVEL(1'b0), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .level(level_v[0]),
    .button(btn_v[0]), .busy(busy_v[0]), .done(done_v[0])
  );

  button_bounce_gen #(
    .BOUNCES(0), .MIN_CYC(MIN_A), .WIDTH_BITS(WB_A), .HOLD_COUNTS(HOLD_A),
    .IDLE_LEVEL(1'b0), .LFSR_SEED(16'hACE1)
  ) dut_b0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .level(level_v[1]),
    .button(btn_v[1]), .busy(busy_v[1]), .done(done_v[1])
  );

  button_bounce_gen #(
    .BOUNCES(4), .MIN_CYC(MIN_C), .WIDTH_BITS(WB_C), .HOLD_COUNTS(HOLD_C),
    .IDLE_LEVEL(1'b0), .LFSR_SEED(16'hACE1)
  ) dut_cl (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .level(level_v[2]),
    .button(btn_v[2]), .busy(busy_v[2]), .done(done_v[2])
  );

  function automatic logic [15:0] model_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic logic [15:0] model_adv(input logic [15:0] v, input int n);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = model_step(r);
    return r;
  endfunction

  // Reference LFSR: reset to the seed, one step per clock.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_m <= 16'hACE1;
    else        lfsr_m <= model_step(lfsr_m);
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Debounce reference: output follows the raw line once it has differed
  // for DELAY consecutive cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db     <= 1'b0;
      db_cnt <= 0;
    end else if (btn_v[2] == db) begin
      db_cnt <= 0;
    end else if (db_cnt == DELAY - 1) begin
      db     <= btn_v[2];
      db_cnt <= 0;
    end else begin
      db_cnt <= db_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (db !== db_prev) begin
      if (db) db_rises = db_rises + 1;
      else    db_falls = db_falls + 1;
      db_cyc = cyc;
    end
    db_prev = db;
  end

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Drive one request on instance sel at the current (post-negedge) time and
  // follow it to done. Returns the global cycle of the last button edge.
  task automatic run_seq(input int sel, input logic lvl, input bit inject,
                         output int last_edge_cyc);
    int          bounces, minc, hold, n_edges, budget;
    logic [15:0] mask, m;
    int          exp_q[$];
    int          seg, t, edges, last_t, busy_bad, inj_t;
    logic        prev, cur;
    bit          seen_done, injected;

    case (sel)
      0:       begin bounces = 3; minc = MIN_A; hold = HOLD_A; mask = 16'h0007; budget = 2000;  end
      1:       begin bounces = 0; minc = MIN_A; hold = HOLD_A; mask = 16'h0007; budget = 2000;  end
      default: begin bounces = 4; minc = MIN_C; hold = HOLD_C; mask = 16'h03FF; budget = 40000; end
    endcase

    prev = btn_v[sel];
    if (lvl != prev) begin
      n_edges = 1 + 2 * bounces;
      m = lfsr_m;
      for (int k = 0; k < n_edges; k++) begin
        seg = minc + int'(m & mask);
        m   = model_adv(m, seg);
        exp_q.push_back((k == n_edges - 1) ? seg + hold : seg);
      end
    end else begin
      n_edges = 0;
      exp_q.push_back(hold);
    end

    start_v[sel] = 1'b1;
    level_v[sel] = lvl;
    @(negedge clk);
    start_v[sel] = 1'b0;

    edges = 0; last_t = 0; busy_bad = 0; inj_t = 0;
    seen_done = 1'b0; injected = 1'b0;
    last_edge_cyc = cyc;

    for (t = 0; t < budget; t++) begin
      if (t > 0) @(negedge clk);
      if (injected && t == inj_t + 1) start_v[sel] = 1'b0;

      cur = btn_v[sel];
      if (cur != prev) begin
        edges++;
        if (edges > 1) begin
          if (exp_q.size() == 0) check("sb_empty_edge", edges, n_edges);
          else check($sformatf("seg_len[%0d] e%0d", sel, edges - 1), t - last_t, exp_q.pop_front());
        end
        last_t        = t;
        last_edge_cyc = cyc;
        prev          = cur;
        if (inject && edges == 2 && !injected) begin
          start_v[sel] = 1'b1;
          level_v[sel] = ~lvl;
          injected     = 1'b1;
          inj_t        = t;
        end
      end

      if (done_v[sel]) begin
        seen_done = 1'b1;
        if (exp_q.size() == 0) check("sb_empty_done", edges, n_edges);
        else check($sformatf("done_delay[%0d]", sel), t - last_t, exp_q.pop_front());
        check($sformatf("busy_at_done[%0d]", sel), int'(busy_v[sel]), 0);
        check($sformatf("edge_count[%0d]", sel), edges, n_edges);
        check($sformatf("final_level[%0d]", sel), int'(btn_v[sel]), int'(lvl));
        break;
      end else if (busy_v[sel] !== 1'b1) begin
        busy_bad++;
      end
    end

    start_v[sel] = 1'b0;
    check($sformatf("done_seen[%0d]", sel), int'(seen_done), 1);
    check($sformatf("busy_during[%0d]", sel), busy_bad, 0);
  endtask

  initial begin
    int   last_edge, rises0, falls0, t;
    int   edges;
    logic prev;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_button", int'(btn_v[0]), 0);
    check("rst_busy",   int'(busy_v[0]), 0);
    check("rst_done",   int'(done_v[0]), 0);
    check("rst_button_b0", int'(btn_v[1]), 0);

    // Rising sequence, then a falling one issued in the done cycle with a
    // stray opposite-level start during the first glitch
    run_seq(0, 1'b1, 1'b0, last_edge);
    run_seq(0, 1'b0, 1'b1, last_edge);

    // No-change request
    @(negedge clk);
    run_seq(0, 1'b0, 1'b0, last_edge);

    // Rise again so the next glitch sits at a level distinct from reset
    @(negedge clk);
    run_seq(0, 1'b1, 1'b0, last_edge);

    // Asynchronous reset while the line is in a glitch of a falling sequence
    @(negedge clk);
    start_v[0] = 1'b1;
    level_v[0] = 1'b0;
    @(negedge clk);
    start_v[0] = 1'b0;
    prev  = 1'b1;
    edges = 0;
    for (t = 0; t < 200; t++) begin
      if (btn_v[0] != prev) begin
        edges++;
        prev = btn_v[0];
      end
      if (edges == 2) break;
      @(negedge clk);
    end
    check("reach_glitch", edges, 2);
    check("glitch_level", int'(btn_v[0]), 1);
    check("busy_before_rst", int'(busy_v[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_button", int'(btn_v[0]), 0);
    check("async_rst_busy",   int'(busy_v[0]), 0);
    check("async_rst_done",   int'(done_v[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // BOUNCES=0: a single edge, one gap, hold, done for one cycle only
    run_seq(1, 1'b1, 1'b0, last_edge);
    @(negedge clk);
    check("done_one_cycle", int'(done_v[1]), 0);

    // Closed loop into the debounce reference: press then release
    rises0 = db_rises;
    falls0 = db_falls;
    run_seq(2, 1'b1, 1'b0, last_edge);
    check("db_rise_count", db_rises - rises0, 1);
    check("db_fall_count_press", db_falls - falls0, 0);
    check("db_rise_latency_ok", int'((db_cyc - last_edge) >= 0 && (db_cyc - last_edge) <= LAT_MAX), 1);

    @(negedge clk);
    rises0 = db_rises;
    falls0 = db_falls;
    run_seq(2, 1'b0, 1'b0, last_edge);
    check("db_fall_count", db_falls - falls0, 1);
    check("db_rise_count_release", db_rises - rises0, 0);
    check("db_fall_latency_ok", int'((db_cyc - last_edge) >= 0 && (db_cyc - last_edge) <= LAT_MAX), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
